approx_add_sched: RTL and testbench

APPROX_ADD_SCHED -- requirements
Module: approx_add_sched

---
 rtl/approx_add_sched.sv | 118 +++++++++++
 tb/tb_approx_add_sched.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_sched.sv
// Two-requester round-robin front end feeding an approximate/exact adder pair,
// with a one-entry result buffer and saturating error statistics.
module approx_add_sched #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned APPROX_BITS = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_src,
   output logic [WIDTH:0]   res_approx,
   output logic [WIDTH:0]   res_exact,
   output logic [WIDTH:0]   res_err,
   input  logic             stat_clr,
   output logic [31:0]      stat_total,
   output logic [31:0]      stat_errs
);

   logic             r_res_valid;
   logic             r_res_src;
   logic [WIDTH:0]   r_res_approx;
   logic [WIDTH:0]   r_res_exact;
   logic [WIDTH:0]   r_res_err;
   logic             r_last;
   logic [31:0]      r_total;
   logic [31:0]      r_errs;

   logic             w_can;
   logic             w_sel1;
   logic             w_accept;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [WIDTH:0]   w_approx;
   logic [WIDTH:0]   w_exact;
   logic [WIDTH:0]   w_err;

   assign w_can = ~r_res_valid | res_ready;

   // Each ready looks only at the other requester's valid and the last grant,
   // so it never depends on its own valid; rst_n forces both low in reset.
   assign req0_ready = rst_n & w_can & (~req1_valid | r_last);
   assign req1_ready = rst_n & w_can & (~req0_valid | ~r_last);

   assign w_sel1   = req1_valid & (~req0_valid | ~r_last);
   assign w_accept = (req0_valid & req0_ready) | (req1_valid & req1_ready);
   assign w_a      = w_sel1 ? req1_a : req0_a;
   assign w_b      = w_sel1 ? req1_b : req0_b;

   always_comb begin
      logic c;
      c        = 1'b0;
      w_approx = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (i < APPROX_BITS) begin
            w_approx[i] = ~w_a[i] & (w_b[i] | c);
            c           = w_a[i] | w_b[i];
         end else begin
            w_approx[i] = w_a[i] ^ w_b[i] ^ c;
            c           = (w_a[i] & w_b[i]) | (c & (w_a[i] ^ w_b[i]));
         end
      end
      w_approx[WIDTH] = c;
   end

   assign w_exact = {1'b0, w_a} + {1'b0, w_b};
   assign w_err   = (w_exact >= w_approx) ? (w_exact - w_approx) : (w_approx - w_exact);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_valid  <= 1'b0;
         r_res_src    <= 1'b0;
         r_res_approx <= '0;
         r_res_exact  <= '0;
         r_res_err    <= '0;
         r_last       <= 1'b1;
      end else if (w_accept) begin
         r_res_valid  <= 1'b1;
         r_res_src    <= w_sel1;
         r_res_approx <= w_approx;
         r_res_exact  <= w_exact;
         r_res_err    <= w_err;
         r_last       <= w_sel1;
      end else if (res_ready) begin
         r_res_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_total <= '0;
         r_errs  <= '0;
      end else if (stat_clr) begin
         r_total <= '0;
         r_errs  <= '0;
      end else if (w_accept) begin
         if (r_total != '1) r_total <= r_total + 32'd1;
         if ((w_err != '0) && (r_errs != '1)) r_errs <= r_errs + 32'd1;
      end
   end

   assign res_valid  = r_res_valid;
   assign res_src    = r_res_src;
   assign res_approx = r_res_approx;
   assign res_exact  = r_res_exact;
   assign res_err    = r_res_err;
   assign stat_total = r_total;
   assign stat_errs  = r_errs;

endmodule

// File: tb/tb_approx_add_sched.sv
// Self-checking bench for approx_add_sched: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_approx_add_sched;

   localparam int W  = 16;
   localparam int AB = 11;

   logic         clk, rst_n;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         res_valid, res_ready, res_src, stat_clr;
   logic [W:0]   res_approx, res_exact, res_err;
   logic [31:0]  stat_total, stat_errs;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   bit          m_valid, m_src, m_last;
   logic [W:0]  m_approx, m_exact, m_err;
   logic [31:0] m_total, m_errs;

   approx_add_sched #(.WIDTH(W), .APPROX_BITS(AB)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
      .res_approx(res_approx), .res_exact(res_exact), .res_err(res_err),
      .stat_clr(stat_clr), .stat_total(stat_total), .stat_errs(stat_errs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Low bits: chain of approximate cells; high bits: ordinary integer addition.
   function automatic logic [W:0] ref_approx(logic [W-1:0] a, logic [W-1:0] b);
      longint unsigned lo = 0;
      longint unsigned la = a;
      longint unsigned lb = b;
      longint unsigned hi;
      bit c = 0;
      for (int i = 0; i < AB; i++) begin
         if (!a[i] && (b[i] || c)) lo = lo | (64'd1 << i);
         c = a[i] || b[i];
      end
      hi = (la >> AB) + (lb >> AB) + longint'(c);
      return (W+1)'(lo + (hi << AB));
   endfunction

   function automatic logic [W:0] ref_exact(logic [W-1:0] a, logic [W-1:0] b);
      longint unsigned la = a;
      longint unsigned lb = b;
      return (W+1)'(la + lb);
   endfunction

   function automatic logic [W:0] ref_err(logic [W-1:0] a, logic [W-1:0] b);
      logic [W:0] e = ref_exact(a, b);
      logic [W:0] p = ref_approx(a, b);
      return (e >= p) ? e - p : p - e;
   endfunction

   task automatic model_reset();
      m_valid = 0; m_src = 0; m_last = 1;
      m_approx = '0; m_exact = '0; m_err = '0;
      m_total = '0; m_errs = '0;
   endtask

   task automatic exp_grant(output bit g0, output bit g1);
      bit can = !m_valid || res_ready;
      g0 = 0; g1 = 0;
      if (can) begin
         if (req0_valid && req1_valid) begin
            if (m_last) g0 = 1; else g1 = 1;
         end else if (req0_valid) g0 = 1;
         else if (req1_valid) g1 = 1;
      end
   endtask

   // Advance one clock edge and update the model from the inputs seen before it.
   task automatic tick();
      bit g0, g1;
      bit         n_valid = m_valid, n_src = m_src, n_last = m_last;
      logic [W:0] n_ap = m_approx, n_ex = m_exact, n_er = m_err;
      logic [W-1:0] a, b;
      logic [31:0] n_tot = m_total, n_errs = m_errs;
      exp_grant(g0, g1);
      if (g0 || g1) begin
         a = g1 ? req1_a : req0_a;
         b = g1 ? req1_b : req0_b;
         n_valid = 1; n_src = g1; n_last = g1;
         n_ap = ref_approx(a, b); n_ex = ref_exact(a, b); n_er = ref_err(a, b);
      end else if (res_ready) n_valid = 0;
      if (stat_clr) begin
         n_tot = 0; n_errs = 0;
      end else if (g0 || g1) begin
         if (n_tot != 32'hFFFF_FFFF) n_tot++;
         if (n_er != 0 && n_errs != 32'hFFFF_FFFF) n_errs++;
      end
      @(posedge clk);
      #1;
      m_valid = n_valid; m_src = n_src; m_last = n_last;
      m_approx = n_ap; m_exact = n_ex; m_err = n_er;
      m_total = n_tot; m_errs = n_errs;
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req1_valid = 0; stat_clr = 0; res_ready = 1;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 0;
      model_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_inputs();
      req0_valid = 1; req1_valid = 1;
      model_reset();
      #1;
      vectors++;
      if ({res_valid, req0_ready, req1_ready, res_src} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got v/r0/r1/src=%b expected 0000",
                  {res_valid, req0_ready, req1_ready, res_src});
      end
      vectors++;
      if ({res_approx, res_exact, res_err, stat_total, stat_errs} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got ap=%h ex=%h er=%h tot=%0d errs=%0d expected all 0",
                  res_approx, res_exact, res_err, stat_total, stat_errs);
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_directed_sums();
      // single requester 1 with an error-producing pair
      req1_valid = 1; req1_a = 16'h0000; req1_b = 16'h0001; res_ready = 1;
      #1;
      vectors++;
      if (req1_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL lone_req1_ready: got %b expected 1", req1_ready);
      end
      tick();
      vectors++;
      if ({res_valid, res_src, res_approx, res_exact, res_err, stat_errs} !==
          {1'b1, 1'b1, 17'h00003, 17'h00001, 17'd2, 32'd1}) begin
         miscompares++;
         $display("FAIL vec_0_1: got v=%b src=%b ap=%h ex=%h er=%0d errs=%0d expected 1 1 00003 00001 2 1",
                  res_valid, res_src, res_approx, res_exact, res_err, stat_errs);
      end
      do_reset();
      req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0000;
      tick();
      vectors++;
      if ({res_approx, res_exact, res_err} !== {17'h00004, 17'h00003, 17'd1}) begin
         miscompares++;
         $display("FAIL vec_3_0: got ap=%h ex=%h er=%0d expected 00004 00003 1",
                  res_approx, res_exact, res_err);
      end
      req0_a = 16'h0001; req0_b = 16'h0001;
      tick();
      vectors++;
      if ({res_approx, res_exact, res_err, stat_total, stat_errs} !==
          {17'h00002, 17'h00002, 17'd0, 32'd2, 32'd1}) begin
         miscompares++;
         $display("FAIL vec_1_1: got ap=%h ex=%h er=%0d tot=%0d errs=%0d expected 00002 00002 0 2 1",
                  res_approx, res_exact, res_err, stat_total, stat_errs);
      end
      req0_a = 16'hF800; req0_b = 16'h0800;
      tick();
      vectors++;
      if ({res_approx, res_exact, res_err} !== {17'h10000, 17'h10000, 17'd0}) begin
         miscompares++;
         $display("FAIL vec_carry_out: got ap=%h ex=%h er=%0d expected 10000 10000 0",
                  res_approx, res_exact, res_err);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_round_robin();
      do_reset();
      req0_valid = 1; req1_valid = 1; res_ready = 1;
      for (int k = 0; k < 4; k++) begin
         req0_a = W'($urandom); req0_b = W'($urandom);
         req1_a = W'($urandom); req1_b = W'($urandom);
         #1;
         vectors++;
         if ({req0_ready, req1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            miscompares++;
            $display("FAIL rr_ready[%0d]: got r0r1=%b expected %b", k, {req0_ready, req1_ready},
                     (k % 2 == 0) ? 2'b10 : 2'b01);
         end
         tick();
         vectors++;
         if ({res_valid, res_src, res_approx, res_exact, res_err} !==
             {1'b1, (k % 2 == 1), m_approx, m_exact, m_err}) begin
            miscompares++;
            $display("FAIL rr_result[%0d]: got v=%b src=%b ap=%h ex=%h er=%h expected 1 %0d %h %h %h",
                     k, res_valid, res_src, res_approx, res_exact, res_err, k % 2, m_approx, m_exact, m_err);
         end
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_back_pressure();
      logic [3*(W+1):0] snap;
      do_reset();
      req0_valid = 1; req0_a = W'($urandom); req0_b = W'($urandom); res_ready = 1;
      tick();
      snap = {res_src, res_approx, res_exact, res_err};
      res_ready = 0; req1_valid = 1;
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      for (int k = 0; k < 3; k++) begin
         #1;
         vectors++;
         if ({req0_ready, req1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL stall_ready[%0d]: got r0r1=%b expected 00", k, {req0_ready, req1_ready});
         end
         tick();
         vectors++;
         if ({res_valid, res_src, res_approx, res_exact, res_err} !== {1'b1, snap}) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got %h expected %h", k,
                     {res_valid, res_src, res_approx, res_exact, res_err}, {1'b1, snap});
         end
      end
      req1_valid = 0; res_ready = 1;
      #1;
      vectors++;
      if (req0_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL drain_reload_ready: got %b expected 1", req0_ready);
      end
      tick();
      vectors++;
      if ({res_valid, res_src, res_approx, res_exact, res_err} !==
          {1'b1, 1'b0, m_approx, m_exact, m_err}) begin
         miscompares++;
         $display("FAIL drain_reload: got v=%b src=%b ap=%h ex=%h er=%h expected 1 0 %h %h %h",
                  res_valid, res_src, res_approx, res_exact, res_err, m_approx, m_exact, m_err);
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_clr_and_reset();
      req0_valid = 1; req0_a = 16'h0003; req0_b = 16'h0000; stat_clr = 1; res_ready = 0;
      tick();
      vectors++;
      if ({res_valid, stat_total, stat_errs} !== {1'b1, 32'd0, 32'd0}) begin
         miscompares++;
         $display("FAIL clr_wins: got v=%b tot=%0d errs=%0d expected 1 0 0",
                  res_valid, stat_total, stat_errs);
      end
      stat_clr = 0;
      #2;
      rst_n = 0;
      model_reset();
      #1;
      vectors++;
      if ({res_valid, req0_ready, req1_ready} !== 3'b000) begin
         miscompares++;
         $display("FAIL async_reset: got v/r0/r1=%b expected 000", {res_valid, req0_ready, req1_ready});
      end
      idle_inputs();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_random();
      bit g0, g1;
      for (int n = 0; n < 1500; n++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         res_ready  = ($urandom_range(0, 3) != 0);
         stat_clr   = ($urandom_range(0, 49) == 0);
         req0_a = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
         req0_b = W'($urandom);
         req1_a = W'($urandom);
         req1_b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
         #1;
         exp_grant(g0, g1);
         vectors++;
         if ({req0_valid & req0_ready, req1_valid & req1_ready} !== {g0, g1}) begin
            miscompares++;
            $display("FAIL rand_grant[%0d]: got %b expected %b", n,
                     {req0_valid & req0_ready, req1_valid & req1_ready}, {g0, g1});
         end
         tick();
         vectors++;
         if (res_valid !== m_valid ||
             (m_valid && {res_src, res_approx, res_exact, res_err} !== {m_src, m_approx, m_exact, m_err})) begin
            miscompares++;
            $display("FAIL rand_result[%0d]: got v=%b src=%b ap=%h ex=%h er=%h expected v=%b src=%b ap=%h ex=%h er=%h",
                     n, res_valid, res_src, res_approx, res_exact, res_err,
                     m_valid, m_src, m_approx, m_exact, m_err);
         end
         vectors++;
         if ({stat_total, stat_errs} !== {m_total, m_errs}) begin
            miscompares++;
            $display("FAIL rand_stats[%0d]: got tot=%0d errs=%0d expected tot=%0d errs=%0d",
                     n, stat_total, stat_errs, m_total, m_errs);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_directed_sums();
      test_round_robin();
      test_back_pressure();
      test_clr_and_reset();
      do_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
